sync_fifo_param: RTL

Single-clock, parametrised FIFO buffer used between pipeline stages that share one clock domain. It generalises the existing 140-bit dual-clock FIFO wrapper with these additions:
- configurable width and depth;
- selectable standard or first-word-fall-through (FWFT) read mode;
- programmable almost-full and almost-empty thresholds;
- an occupancy count;
- sticky overflow and underflow error flags.

Port names match the existing FIFO so the block can drop in on single-clock paths.

---
 rtl/sync_fifo_param.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with optional first-word-fall-through read port,
// programmable almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 140,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned CW       = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_w_enable,
  input  logic [DATA_W-1:0] data_to_fifo,
  input  logic              fifo_r_enable,
  output logic [DATA_W-1:0] data_from_fifo,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  output logic [CW-1:0]     fifo_count,
  input  logic              err_clr,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_TH);
  localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_TH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_empty;
  logic              r_full;
  logic              r_afull;
  logic              r_aempty;
  logic              r_ovf;
  logic              r_udf;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [CW-1:0]     w_count_nxt;

  assign w_wr_acc = fifo_w_enable & ~r_full;
  assign w_rd_acc = fifo_r_enable & ~r_empty;

  // Occupancy only moves when exactly one side is accepted.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_to_fifo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + CW'(1);
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == C_DEPTH);
      r_afull  <= (w_count_nxt >= C_AFULL);
      r_aempty <= (w_count_nxt <= C_AEMPTY);
    end
  end

  // Sticky errors: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (fifo_w_enable && r_full)    r_ovf <= 1'b1;
      else if (err_clr)               r_ovf <= 1'b0;
      if (fifo_r_enable && r_empty)   r_udf <= 1'b1;
      else if (err_clr)               r_udf <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_from_fifo = r_mem[r_rd_ptr[AW-1:0]];
    end else begin : g_std
      logic [DATA_W-1:0] r_dout;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dout <= '0;
        end else if (w_rd_acc) begin
          r_dout <= r_mem[r_rd_ptr[AW-1:0]];
        end
      end
      assign data_from_fifo = r_dout;
    end
  endgenerate

  assign fifo_count        = r_count;
  assign fifo_empty        = r_empty;
  assign fifo_full         = r_full;
  assign fifo_almost_full  = r_afull;
  assign fifo_almost_empty = r_aempty;
  assign fifo_overflow     = r_ovf;
  assign fifo_underflow    = r_udf;

  // Pointer distance must always agree with the registered count.
  a_ptr_count : assert property (@(posedge clk) disable iff (!rst_n)
    ((r_wr_ptr - r_rd_ptr) == r_count) && (r_count <= C_DEPTH));

endmodule
